tdm_frame_sched: RTL

TDM_FRAME_SCHED -- requirements
Module: tdm_frame_sched

---
 rtl/tdm_frame_sched.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/tdm_frame_sched.sv
// TDM frame scheduler: walks channel/bit slots and prefetches each active channel's data.
// Build option TDM_SCHED_GRAY_EN presents bit_num as the Gray code of the slot count.
//
// state | meaning
// IDLE  | stopped, outputs quiet, frame_cnt held
// PRIME | waiting for channel 0 data before the first frame (no timeout)
// RUN   | sequencing slots, fetching ahead for every active channel
// DRAIN | finishing the current frame; channel 0 of the next frame is not fetched
module tdm_frame_sched #(
  parameter int NUM_CH       = 32,
  parameter int PREFETCH_BIT = 4
) (
  input  logic        serial_clk_inv,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] ch_mask,
  input  logic        fetch_ack,
  output logic        frame_sync,
  output logic [4:0]  ch_num,
  output logic [2:0]  bit_num,
  output logic        fetch_req,
  output logic [4:0]  fetch_ch,
  output logic        load_stb,
  output logic        load_valid,
  output logic        underrun,
  output logic [7:0]  frame_cnt,
  output logic        busy
);

  localparam logic [4:0] LAST_CH = 5'(NUM_CH - 1);
  localparam logic [2:0] PF_SLOT = 3'(PREFETCH_BIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  ch_q, ch_d;
  logic [2:0]  bit_q, bit_d;
  logic        req_q, req_d;
  logic [4:0]  fch_q, fch_d;
  logic        ready_q, ready_d;
  logic        cur_valid_q, cur_valid_d;
  logic        cur_urun_q, cur_urun_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic        active;
  logic        ack_ok;
  logic        last_bit;
  logic        last_ch;
  logic [4:0]  nxt_ch;

  always_ff @(posedge serial_clk_inv or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ch_q        <= 5'd0;
      bit_q       <= 3'd0;
      req_q       <= 1'b0;
      fch_q       <= 5'd0;
      ready_q     <= 1'b0;
      cur_valid_q <= 1'b0;
      cur_urun_q  <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      bit_q       <= bit_d;
      req_q       <= req_d;
      fch_q       <= fch_d;
      ready_q     <= ready_d;
      cur_valid_q <= cur_valid_d;
      cur_urun_q  <= cur_urun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    active   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    ack_ok   = req_q && fetch_ack;
    last_bit = (bit_q == 3'd7);
    last_ch  = (ch_q == LAST_CH);
    nxt_ch   = last_ch ? 5'd0 : ch_q + 5'd1;
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    bit_d       = bit_q;
    req_d       = req_q;
    fch_d       = fch_q;
    ready_d     = ready_q;
    cur_valid_d = cur_valid_q;
    cur_urun_d  = cur_urun_q;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        ch_d    = 5'd0;
        bit_d   = 3'd0;
        req_d   = 1'b0;
        ready_d = 1'b0;
        if (enable) begin
          if (ch_mask[0]) begin
            state_d = ST_PRIME;
            req_d   = 1'b1;
            fch_d   = 5'd0;
          end else begin
            state_d     = ST_RUN;
            cur_valid_d = 1'b0;
            cur_urun_d  = 1'b0;
          end
        end
      end

      ST_PRIME: begin
        if (ack_ok) begin
          state_d     = ST_RUN;
          req_d       = 1'b0;
          ready_d     = 1'b0;
          cur_valid_d = 1'b1;
          cur_urun_d  = 1'b0;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (state_q == ST_RUN)
          state_d = enable ? ST_RUN : ST_DRAIN;
        else if (enable)
          state_d = ST_RUN;
        else if (last_bit && last_ch)
          state_d = ST_IDLE;
        else
          state_d = ST_DRAIN;

        bit_d = bit_q + 3'd1;

        if (ack_ok) begin
          req_d   = 1'b0;
          ready_d = 1'b1;
        end

        // A draining frame must not request data for a frame that will never run.
        if (bit_q == PF_SLOT && ch_mask[nxt_ch] &&
            !(state_q == ST_DRAIN && nxt_ch == 5'd0)) begin
          req_d   = 1'b1;
          fch_d   = nxt_ch;
          ready_d = 1'b0;
        end

        // Channel boundary: an ack in this very slot still counts; a live request expires.
        if (last_bit) begin
          ch_d        = nxt_ch;
          cur_valid_d = ready_q || ack_ok;
          cur_urun_d  = req_q && !fetch_ack;
          req_d       = 1'b0;
          ready_d     = 1'b0;
          if (last_ch)
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign frame_sync = active && (ch_q == 5'd0);
  assign ch_num     = ch_q;
  assign fetch_req  = req_q;
  assign fetch_ch   = fch_q;
  assign load_stb   = active && (bit_q == 3'd0);
  assign load_valid = load_stb && cur_valid_q;
  assign underrun   = load_stb && cur_urun_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef TDM_SCHED_GRAY_EN
  assign bit_num = bit_q ^ (bit_q >> 1);
`else
  assign bit_num = bit_q;
`endif

endmodule
